// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizing for the cache-to-burst-memory arbiter.
package mem_arbiter_pkg;

    localparam int LINE_W     = 256;
    localparam int BEAT_W     = 64;
    localparam int BEATS      = LINE_W / BEAT_W;
    localparam int BEAT_IDX_W = $clog2(BEATS);

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } arb_owner_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_CMD  = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        RESP    = 3'd4
    } arb_state_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFE0;
    endfunction

endpackage

// File: rtl/mem_arbiter_burst_line_buf.sv
// Line accumulator with beat index: gathers read beats and serves write beats,
// so the same storage is used in both burst directions.
module burst_line_buf
    import mem_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [LINE_W-1:0]     load_line,
    input  logic                  beat_we,
    input  logic                  beat_adv,
    input  logic [BEAT_W-1:0]     beat_in,
    input  logic [BEAT_IDX_W-1:0] sel_idx,
    output logic [LINE_W-1:0]     line_out,
    output logic [BEAT_IDX_W-1:0] idx_out,
    output logic [BEAT_W-1:0]     beat_out
);

    logic [LINE_W-1:0]     line_q, line_d;
    logic [BEAT_IDX_W-1:0] idx_q, idx_d;

    // Next line contents and beat index; the index wraps to 0 after the last beat.
    always_comb begin
        line_d = line_q;
        idx_d  = idx_q;
        if (load) begin
            line_d = load_line;
            idx_d  = {BEAT_IDX_W{1'b0}};
        end else if (beat_adv) begin
            if (beat_we) begin
                line_d[idx_q*BEAT_W +: BEAT_W] = beat_in;
            end else begin
                line_d = line_q;
            end
            idx_d = idx_q + BEAT_IDX_W'(1);
        end else begin
            line_d = line_q;
            idx_d  = idx_q;
        end
    end

    // Accumulator and index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= {LINE_W{1'b0}};
            idx_q  <= {BEAT_IDX_W{1'b0}};
        end else begin
            line_q <= line_d;
            idx_q  <= idx_d;
        end
    end

    assign line_out = line_q;
    assign idx_out  = idx_q;
    assign beat_out = line_q[sel_idx*BEAT_W +: BEAT_W];

endmodule

// File: rtl/mem_arbiter_checker.sv
// Simulation-only protocol checks on the arbiter's cache-side inputs.
module mem_arbiter_checker (
    input logic clk,
    input logic rst,
    input logic d_read,
    input logic d_write
);

    a_no_rd_wr_together: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write))
        else $error("mem_arbiter: d_read and d_write asserted together");

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 64-bit burst memory port between the
// instruction fetcher and data cache; one 256-bit line transaction at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [31:0]       d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [31:0]       bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    arb_state_t  state_q, state_d;
    arb_owner_t  owner_q, owner_d;
    arb_owner_t  last_grant_q, last_grant_d;
    logic        is_write_q, is_write_d;
    logic [31:0] addr_q, addr_d;

    logic              i_resp_q, i_resp_d;
    logic              d_resp_q, d_resp_d;
    logic              bmem_read_q, bmem_read_d;
    logic              bmem_write_q, bmem_write_d;
    logic [31:0]       bmem_addr_q, bmem_addr_d;
    logic [BEAT_W-1:0] bmem_wdata_q, bmem_wdata_d;

    logic                  grant_data;
    logic                  buf_load, buf_we, buf_adv;
    logic [LINE_W-1:0]     buf_load_line;
    logic [LINE_W-1:0]     buf_line;
    logic [BEAT_IDX_W-1:0] buf_idx, idx_next;
    logic [BEAT_W-1:0]     buf_beat;

    // Arbitration, burst sequencing and next values of all registered outputs.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        is_write_d    = is_write_q;
        addr_d        = addr_q;
        grant_data    = 1'b0;
        buf_load      = 1'b0;
        buf_we        = 1'b0;
        buf_adv       = 1'b0;
        buf_load_line = {LINE_W{1'b0}};

        case (state_q)
            IDLE: begin
                if (i_read && (d_read || d_write)) begin
                    grant_data = (last_grant_q == OWNER_INST);
                end else begin
                    grant_data = d_read || d_write;
                end
                if (i_read || d_read || d_write) begin
                    owner_d       = grant_data ? OWNER_DATA : OWNER_INST;
                    last_grant_d  = grant_data ? OWNER_DATA : OWNER_INST;
                    is_write_d    = grant_data && d_write;
                    addr_d        = line_align(grant_data ? d_addr : i_addr);
                    buf_load      = 1'b1;
                    buf_load_line = (grant_data && d_write) ? d_wdata : {LINE_W{1'b0}};
                    state_d       = (grant_data && d_write) ? WR_DATA : RD_CMD;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_CMD: begin
                if (bmem_ready) begin
                    state_d = RD_DATA;
                end else begin
                    state_d = RD_CMD;
                end
            end
            RD_DATA: begin
                // Beats tagged with another address belong to someone else.
                if (bmem_rvalid && (bmem_raddr == addr_q)) begin
                    buf_we  = 1'b1;
                    buf_adv = 1'b1;
                    if (buf_idx == BEAT_IDX_W'(BEATS - 1)) begin
                        state_d = RESP;
                    end else begin
                        state_d = RD_DATA;
                    end
                end else begin
                    state_d = RD_DATA;
                end
            end
            WR_DATA: begin
                if (bmem_ready) begin
                    buf_adv = 1'b1;
                    if (buf_idx == BEAT_IDX_W'(BEATS - 1)) begin
                        state_d = RESP;
                    end else begin
                        state_d = WR_DATA;
                    end
                end else begin
                    state_d = WR_DATA;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (buf_load) begin
            idx_next = {BEAT_IDX_W{1'b0}};
        end else if (buf_adv) begin
            idx_next = buf_idx + BEAT_IDX_W'(1);
        end else begin
            idx_next = buf_idx;
        end

        bmem_read_d  = (state_d == RD_CMD);
        bmem_write_d = (state_d == WR_DATA);
        if ((state_d == RD_CMD) || (state_d == WR_DATA)) begin
            bmem_addr_d = addr_d;
        end else begin
            bmem_addr_d = 32'h0000_0000;
        end

        // On the grant edge the buffer is not loaded yet, so beat 0 comes straight from the port.
        if (state_d == WR_DATA) begin
            if (buf_load) begin
                bmem_wdata_d = d_wdata[BEAT_W-1:0];
            end else begin
                bmem_wdata_d = buf_beat;
            end
        end else begin
            bmem_wdata_d = {BEAT_W{1'b0}};
        end

        i_resp_d = (state_d == RESP) && (owner_q == OWNER_INST);
        d_resp_d = (state_d == RESP) && (owner_q == OWNER_DATA);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_INST;
            last_grant_q <= OWNER_INST;
            is_write_q   <= 1'b0;
            addr_q       <= 32'h0000_0000;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
            bmem_read_q  <= 1'b0;
            bmem_write_q <= 1'b0;
            bmem_addr_q  <= 32'h0000_0000;
            bmem_wdata_q <= {BEAT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            is_write_q   <= is_write_d;
            addr_q       <= addr_d;
            i_resp_q     <= i_resp_d;
            d_resp_q     <= d_resp_d;
            bmem_read_q  <= bmem_read_d;
            bmem_write_q <= bmem_write_d;
            bmem_addr_q  <= bmem_addr_d;
            bmem_wdata_q <= bmem_wdata_d;
        end
    end

    burst_line_buf u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .load_line (buf_load_line),
        .beat_we   (buf_we),
        .beat_adv  (buf_adv),
        .beat_in   (bmem_rdata),
        .sel_idx   (idx_next),
        .line_out  (buf_line),
        .idx_out   (buf_idx),
        .beat_out  (buf_beat)
    );

    mem_arbiter_checker u_checker (
        .clk     (clk),
        .rst     (rst),
        .d_read  (d_read),
        .d_write (d_write)
    );

    assign i_rdata    = buf_line;
    assign d_rdata    = buf_line;
    assign i_resp     = i_resp_q;
    assign d_resp     = d_resp_q;
    assign bmem_read  = bmem_read_q;
    assign bmem_write = bmem_write_q;
    assign bmem_addr  = bmem_addr_q;
    assign bmem_wdata = bmem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the initial block plays both caches and the memory.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_addr;
    logic         i_read;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic [31:0]  d_addr;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .i_addr      (i_addr),
        .i_read      (i_read),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_addr      (d_addr),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [7:0] s);
        return {s, 56'h3, s, 56'h2, s, 56'h1, s, 56'h0};
    endfunction

    task automatic beats(input logic [31:0] a, input logic [255:0] ln);
        for (int k = 0; k < 4; k++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = a;
            bmem_rdata  = ln[64*k +: 64];
            cyc();
        end
        bmem_rvalid = 1'b0;
    endtask

    // Called in the grant cycle; returns in the idle cycle after the response.
    task automatic read_txn(input string tag, input logic [31:0] a, input logic inst,
                            input logic [255:0] ln, input logic drop);
        cyc();
        chk($sformatf("%s_cmd", tag), {255'd0, bmem_read}, 256'd1);
        chk($sformatf("%s_addr", tag), {224'd0, bmem_addr}, {224'd0, a});
        cyc();
        chk($sformatf("%s_cmd_off", tag), {255'd0, bmem_read}, 256'd0);
        beats(a, ln);
        chk($sformatf("%s_iresp", tag), {255'd0, i_resp}, {255'd0, inst});
        chk($sformatf("%s_dresp", tag), {255'd0, d_resp}, {255'd0, ~inst});
        chk($sformatf("%s_rdata", tag), inst ? i_rdata : d_rdata, ln);
        if (drop) begin
            i_read = 1'b0;
            d_read = 1'b0;
        end
        cyc();
        chk($sformatf("%s_resp_off", tag), {254'd0, i_resp, d_resp}, 256'd0);
    endtask

    logic [255:0] ln;
    logic [255:0] wline;
    logic [31:0]  sa [5];
    logic [63:0]  sd [5];

    initial begin
        rst = 1'b1; i_addr = 32'h0; i_read = 1'b0; d_addr = 32'h0; d_read = 1'b0;
        d_write = 1'b0; d_wdata = 256'h0; bmem_ready = 1'b0; bmem_raddr = 32'h0;
        bmem_rdata = 64'h0; bmem_rvalid = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_iresp", {255'd0, i_resp}, 256'd0);
        chk("rst_dresp", {255'd0, d_resp}, 256'd0);
        chk("rst_bread", {255'd0, bmem_read}, 256'd0);
        chk("rst_bwrite", {255'd0, bmem_write}, 256'd0);
        chk("rst_baddr", {224'd0, bmem_addr}, 256'd0);
        chk("rst_bwdata", {192'd0, bmem_wdata}, 256'd0);
        chk("rst_irdata", i_rdata, 256'd0);
        chk("rst_drdata", d_rdata, 256'd0);

        // Lone instruction read of an unaligned address.
        i_read = 1'b1; i_addr = 32'h0000_1234; bmem_ready = 1'b1;
        ln = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        read_txn("iread", 32'h0000_1220, 1'b1, ln, 1'b1);
        cyc();
        chk("iread_no_regrant", {255'd0, bmem_read}, 256'd0);

        // Both sides from reset: data first, then strict alternation.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        i_read = 1'b1; i_addr = 32'h0000_0100;
        d_read = 1'b1; d_addr = 32'h0000_0200;
        for (int t = 0; t < 4; t++) begin
            read_txn($sformatf("alt%0d", t), (t % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100,
                     (t % 2 == 1), mk_line(8'hA0 + 8'(t)), (t == 3));
        end

        // Writeback with a three-cycle stall on beat 1.
        wline = 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;
        d_write = 1'b1; d_addr = 32'h0000_0040; d_wdata = wline; bmem_ready = 1'b1;
        cyc();
        chk("wr_valid0", {255'd0, bmem_write}, 256'd1);
        chk("wr_addr", {224'd0, bmem_addr}, 256'h40);
        chk("wr_beat0", {192'd0, bmem_wdata}, {192'd0, wline[63:0]});
        cyc();
        chk("wr_beat1", {192'd0, bmem_wdata}, {192'd0, wline[127:64]});
        bmem_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            cyc();
            chk($sformatf("wr_hold%0d", s), {191'd0, bmem_write, bmem_wdata},
                {191'd0, 1'b1, wline[127:64]});
        end
        bmem_ready = 1'b1;
        cyc();
        chk("wr_beat2", {192'd0, bmem_wdata}, {192'd0, wline[191:128]});
        cyc();
        chk("wr_beat3", {192'd0, bmem_wdata}, {192'd0, wline[255:192]});
        chk("wr_no_early_resp", {255'd0, d_resp}, 256'd0);
        cyc();
        chk("wr_dresp", {254'd0, d_resp, i_resp}, 256'd2);
        chk("wr_valid_off", {255'd0, bmem_write}, 256'd0);
        d_write = 1'b0;
        cyc();
        chk("wr_dresp_off", {255'd0, d_resp}, 256'd0);

        // Read with the command stalled for five cycles.
        i_read = 1'b1; i_addr = 32'h0000_0580; bmem_ready = 1'b0;
        cyc();
        chk("stall_cmd0", {223'd0, bmem_read, bmem_addr}, {223'd0, 1'b1, 32'h0000_0580});
        for (int s = 1; s < 5; s++) begin
            cyc();
            chk($sformatf("stall_cmd%0d", s), {223'd0, bmem_read, bmem_addr},
                {223'd0, 1'b1, 32'h0000_0580});
        end
        bmem_ready = 1'b1;
        cyc();
        chk("stall_cmd_off", {255'd0, bmem_read}, 256'd0);
        beats(32'h0000_0580, mk_line(8'h58));
        chk("stall_iresp", {255'd0, i_resp}, 256'd1);
        chk("stall_rdata", i_rdata, mk_line(8'h58));
        i_read = 1'b0;
        cyc();

        // Stray beat for another address in the middle of a data read.
        d_read = 1'b1; d_addr = 32'h0000_0300;
        ln = mk_line(8'h30);
        sa[0] = 32'h0000_0300; sd[0] = ln[63:0];
        sa[1] = 32'hDEAD_0000; sd[1] = 64'hBAD0_BAD0_BAD0_BAD0;
        sa[2] = 32'h0000_0300; sd[2] = ln[127:64];
        sa[3] = 32'h0000_0300; sd[3] = ln[191:128];
        sa[4] = 32'h0000_0300; sd[4] = ln[255:192];
        cyc();
        chk("stray_cmd", {223'd0, bmem_read, bmem_addr}, {223'd0, 1'b1, 32'h0000_0300});
        cyc();
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                chk("stray_no_early_resp", {255'd0, d_resp}, 256'd0);
            end
            bmem_rvalid = 1'b1; bmem_raddr = sa[k]; bmem_rdata = sd[k];
            cyc();
        end
        bmem_rvalid = 1'b0;
        chk("stray_dresp", {255'd0, d_resp}, 256'd1);
        chk("stray_rdata", d_rdata, ln);
        d_read = 1'b0;
        cyc();

        // Reset after three beats of a read, then a clean read.
        i_read = 1'b1; i_addr = 32'h0000_0700;
        ln = mk_line(8'h70);
        cyc();
        chk("rstm_cmd", {255'd0, bmem_read}, 256'd1);
        cyc();
        for (int k = 0; k < 3; k++) begin
            bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0700; bmem_rdata = ln[64*k +: 64];
            cyc();
        end
        rst = 1'b1; i_read = 1'b0;
        bmem_rdata = ln[255:192];
        cyc();
        rst = 1'b0;
        chk("rstm_iresp", {255'd0, i_resp}, 256'd0);
        chk("rstm_dresp", {255'd0, d_resp}, 256'd0);
        chk("rstm_bus", {190'd0, bmem_read, bmem_write, bmem_addr}, 256'd0);
        chk("rstm_bwdata", {192'd0, bmem_wdata}, 256'd0);
        chk("rstm_irdata", i_rdata, 256'd0);
        chk("rstm_drdata", d_rdata, 256'd0);
        cyc();
        chk("rstm_late_beat", i_rdata, 256'd0);
        chk("rstm_late_resp", {255'd0, i_resp}, 256'd0);
        bmem_rvalid = 1'b0;
        i_read = 1'b1; i_addr = 32'h0000_0800;
        read_txn("rstm_new", 32'h0000_0800, 1'b1, mk_line(8'h77), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
